// File: rtl/sram_req_arbiter.sv
`timescale 1ns/100ps
// Arbitrates instruction-fetch and data requests onto one SRAM-like bus port.
// Data wins in IDLE; a stalled request (bus_addr_ok low) locks the bus to its
// requester until accepted. A small owner FIFO routes in-order responses back
// and drops fetch responses squashed by flush.
module sram_req_arbiter #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    input  logic        flush,

    output logic        bus_req,
    output logic        bus_wr,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCK_I = 2'd1,
        LOCK_D = 2'd2
    } state_t;

    state_t           state;
    logic             flush_seen;

    // Response-owner FIFO: owner 1 = data, 0 = inst; disc marks squashed fetches.
    logic             owner_q [DEPTH];
    logic             disc_q  [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [CNT_W-1:0] count;

    logic             full;
    logic             empty;
    logic             grant_i;
    logic             grant_d;
    logic             push;
    logic             push_disc;
    logic             pop;
    logic             head_owner;
    logic             head_disc;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    // Grant selection: data priority in IDLE, sticky owner while locked.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (resetn) begin
            case (state)
                IDLE: begin
                    if (!full) begin
                        if (data_req)      grant_d = 1'b1;
                        else if (inst_req) grant_i = 1'b1;
                    end
                end
                LOCK_I:  grant_i = inst_req;
                LOCK_D:  grant_d = data_req;
                default: ;
            endcase
        end
    end

    assign bus_req   = grant_i | grant_d;
    assign bus_wr    = grant_d & data_wr;
    assign bus_wstrb = grant_d ? data_wstrb : 4'h0;
    assign bus_wdata = grant_d ? data_wdata : 32'h0;
    assign bus_addr  = grant_d ? data_addr : (grant_i ? inst_addr : 32'h0);

    assign inst_addr_ok = grant_i & bus_addr_ok;
    assign data_addr_ok = grant_d & bus_addr_ok;

    assign push      = bus_req & bus_addr_ok;
    assign push_disc = grant_i & (flush | flush_seen);
    assign pop       = bus_data_ok & ~empty;

    assign head_owner = owner_q[rptr];
    // A flush in the pop cycle still squashes the fetch being returned.
    assign head_disc  = disc_q[rptr] | flush;

    assign data_data_ok = pop & head_owner;
    assign inst_data_ok = pop & ~head_owner & ~head_disc;

    assign inst_rdata = bus_rdata;
    assign data_rdata = bus_rdata;

    // Lock FSM plus the flush-while-locked-on-inst flag.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            flush_seen <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    flush_seen <= 1'b0;
                    if (bus_req && !bus_addr_ok) begin
                        state <= grant_d ? LOCK_D : LOCK_I;
                    end
                end
                LOCK_I: begin
                    if (bus_addr_ok) begin
                        state      <= IDLE;
                        flush_seen <= 1'b0;
                    end else if (flush) begin
                        flush_seen <= 1'b1;
                    end
                end
                LOCK_D: begin
                    if (bus_addr_ok) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state      <= IDLE;
                    flush_seen <= 1'b0;
                end
            endcase
        end
    end

    // Owner FIFO storage, pointers and occupancy.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                owner_q[i] <= 1'b0;
                disc_q[i]  <= 1'b0;
            end
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (push && (wptr == PTR_W'(i))) begin
                    owner_q[i] <= grant_d;
                    disc_q[i]  <= push_disc;
                end else if (flush && !owner_q[i]) begin
                    disc_q[i] <= 1'b1;
                end
            end
            if (push) wptr <= wptr + PTR_W'(1);
            if (pop)  rptr <= rptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

endmodule
